// File: rtl/char_receiver.sv
// Serial character receiver: mid-bit sampling of start, data (LSB first) and stop bits,
// with a single-entry output register offering a valid/ready handshake and overrun detection.
module char_receiver #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serialDataIn,
   input  logic                 enable,
   input  logic                 dataReady,
   output logic                 charReceived,
   output logic [DATA_BITS-1:0] dataOut,
   output logic                 dataValid,
   output logic                 framingError,
   output logic                 overrun
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shift_q;

   logic cnt_half, cnt_full, load, accept;

   always_comb begin
      cnt_half = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
      cnt_full = (cnt_q == CW'(CLKS_PER_BIT - 1));
      load     = (state_q == StStop) && enable && cnt_full;
      accept   = dataValid && dataReady;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         charReceived <= 1'b0;
         dataOut      <= '0;
         dataValid    <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         charReceived <= 1'b0;

         // Output register: a load wins over an accept; a load into an unread slot is an overrun.
         if (load) begin
            dataOut      <= shift_q;
            dataValid    <= 1'b1;
            framingError <= ~serialDataIn;
            overrun      <= dataValid & ~dataReady;
         end else if (accept) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               idx_q <= '0;
               if (enable) begin
                  state_q <= StStart;
                  shift_q <= '0;
               end
            end
            StStart: begin
               if (!enable) begin
                  state_q <= StIdle;
               end else if (cnt_half) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  if (!serialDataIn) begin
                     state_q <= StData;
                  end else begin
                     state_q      <= StDone;
                     charReceived <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StData: begin
               if (!enable) begin
                  state_q <= StIdle;
               end else if (cnt_full) begin
                  shift_q[idx_q] <= serialDataIn;
                  cnt_q          <= '0;
                  if (idx_q == IW'(DATA_BITS - 1)) begin
                     state_q <= StStop;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StStop: begin
               if (!enable) begin
                  state_q <= StIdle;
               end else if (cnt_full) begin
                  state_q      <= StDone;
                  cnt_q        <= '0;
                  charReceived <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_receiver.sv
// Bench for char_receiver: directed and randomized frames checked every cycle against a
// transaction-level model of the line timing and the output register.
module tb_char_receiver;

   localparam int CPB     = 16;
   localparam int DB      = 8;
   localparam int H       = CPB / 2;
   localparam int FRAME_T = 1 + H + (DB + 1) * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          serialDataIn = 1'b1;
   logic          enable = 1'b0;
   logic          dataReady = 1'b0;
   logic          charReceived;
   logic [DB-1:0] dataOut;
   logic          dataValid;
   logic          framingError;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   logic          exp_valid, exp_fe, exp_ovr;
   logic [DB-1:0] exp_data;

   always #5 clk = ~clk;

   char_receiver #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .serialDataIn(serialDataIn),
      .enable      (enable),
      .dataReady   (dataReady),
      .charReceived(charReceived),
      .dataOut     (dataOut),
      .dataValid   (dataValid),
      .framingError(framingError),
      .overrun     (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic exp_cr);
      chk({tag, ".charReceived"}, 32'(charReceived), 32'(exp_cr));
      chk({tag, ".dataValid"}, 32'(dataValid), 32'(exp_valid));
      chk({tag, ".dataOut"}, 32'(dataOut), 32'(exp_data));
      chk({tag, ".framingError"}, 32'(framingError), 32'(exp_fe));
      chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
   endtask

   task automatic model_reset();
      exp_valid = 1'b0;
      exp_fe    = 1'b0;
      exp_ovr   = 1'b0;
      exp_data  = '0;
   endtask

   // One clock edge of the consumer-side register, using the dataReady seen at that edge.
   task automatic model_edge(input logic load, input logic [DB-1:0] d, input logic stop);
      if (load) begin
         exp_ovr   = exp_valid & ~dataReady;
         exp_valid = 1'b1;
         exp_data  = d;
         exp_fe    = ~stop;
      end else if (exp_valid && dataReady) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   // Line level for the bit period that covers the edge after negedge t.
   function automatic logic line_at(input int t, input logic [DB-1:0] d, input logic stop,
                                    input int start_len);
      int seg;
      seg = t / CPB;
      if (seg == 0) return (t < start_len) ? 1'b0 : 1'b1;
      if (seg <= DB) return d[seg-1];
      if (seg == DB + 1) return stop;
      return 1'b1;
   endfunction

   task automatic idle(input int n, input logic rdy);
      dataReady = rdy;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         model_edge(1'b0, '0, 1'b1);
         check_outputs("idle", 1'b0);
      end
   endtask

   // abort_kind: 0 none, 1 reset pulse at abort_t, 2 enable dropped at abort_t.
   task automatic frame(input string tag, input logic [DB-1:0] d, input logic stop,
                        input int start_len, input logic rdy, input int abort_kind,
                        input int abort_t);
      logic false_start;
      int   exp_t;
      false_start  = (start_len <= H);
      exp_t        = false_start ? 1 + H : FRAME_T;
      dataReady    = rdy;
      enable       = 1'b1;
      serialDataIn = line_at(0, d, stop, start_len);
      for (int t = 1; t <= exp_t + 1; t++) begin
         @(negedge clk);
         model_edge(!false_start && (t == exp_t), d, stop);
         check_outputs(tag, 1'(t == exp_t));
         if (t >= exp_t) begin
            enable       = 1'b0;
            serialDataIn = 1'b1;
         end else begin
            serialDataIn = line_at(t, d, stop, start_len);
         end
         if (abort_kind == 1 && t == abort_t) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_outputs({tag, ".in_reset"}, 1'b0);
            @(negedge clk);
            check_outputs({tag, ".held_reset"}, 1'b0);
            rst          = 1'b1;
            enable       = 1'b0;
            serialDataIn = 1'b1;
            return;
         end
         if (abort_kind == 2 && t == abort_t) begin
            enable       = 1'b0;
            serialDataIn = 1'b1;
            idle(4, rdy);
            return;
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset", 1'b0);
      rst = 1'b1;
      idle(3, 1'b1);

      frame("a5", 8'hA5, 1'b1, CPB, 1'b1, 0, 0);
      idle(4, 1'b1);

      frame("3c_fe", 8'h3C, 1'b0, CPB, 1'b0, 0, 0);
      idle(2, 1'b1);

      frame("glitch", 8'hFF, 1'b1, 4, 1'b1, 0, 0);
      idle(3, 1'b1);

      frame("x11", 8'h11, 1'b1, CPB, 1'b0, 0, 0);
      idle(3, 1'b0);
      frame("x22", 8'h22, 1'b1, CPB, 1'b0, 0, 0);
      idle(3, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b0);

      frame("x33", 8'h33, 1'b1, CPB, 1'b0, 0, 0);
      frame("x34", 8'h34, 1'b1, CPB, 1'b0, 0, 0);
      idle(2, 1'b0);
      frame("x44_accept_load", 8'h44, 1'b1, CPB, 1'b1, 0, 0);
      idle(3, 1'b1);

      frame("rst_abort", 8'hFF, 1'b1, CPB, 1'b1, 1, 70);
      idle(3, 1'b1);
      frame("x5a", 8'h5A, 1'b1, CPB, 1'b1, 0, 0);
      idle(3, 1'b1);

      frame("en_drop", 8'h77, 1'b1, CPB, 1'b1, 2, 100);
      idle(2, 1'b1);

      repeat (14) begin
         frame("rnd", DB'($urandom), 1'($urandom_range(0, 3) != 0), int'($urandom_range(2, CPB)),
               1'($urandom % 2), 0, 0);
         idle(int'($urandom_range(1, 5)), 1'($urandom % 2));
      end
      idle(3, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/char_receiver.md
CHAR_RECEIVER -- requirements
Module: char_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; it SHALL be an even value of at least 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the number of data bits per character.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port serialDataIn, input, 1 bit: serial line; idles high; start bit 0; DATA_BITS data bits LSB first; stop bit 1.
REQ-007 Port enable, input, 1 bit: frame-active indication from the upstream start-bit detector.
REQ-008 Port dataReady, input, 1 bit: the consumer accepts dataOut on any cycle where dataValid=1 and dataReady=1.
REQ-009 Port charReceived, output, 1 bit: one-cycle pulse ending the frame; returns the start-bit detector to idle.
REQ-010 Port dataOut, output, DATA_BITS bits: the last received character.
REQ-011 Port dataValid, output, 1 bit: dataOut holds an unaccepted character.
REQ-012 Port framingError, output, 1 bit: the stop bit of the character in dataOut was sampled as 0.
REQ-013 Port overrun, output, 1 bit: sticky; an unaccepted character was overwritten.

Function
REQ-014 The block SHALL implement the states IDLE, START, DATA, STOP and DONE, with a cycle counter and a bit index.
REQ-015 IDLE: on the first clock edge with enable=1, the block SHALL go to START with counter=0.
REQ-016 START: when counter reaches CLKS_PER_BIT/2-1, the block SHALL sample serialDataIn.
  - Sample 0: go to DATA, counter=0, bit index=0.
  - Sample 1 (false start): go to DONE; no data is loaded and the output flags are unchanged.
REQ-017 DATA: when counter reaches CLKS_PER_BIT-1, the block SHALL shift serialDataIn into bit[index] and reset the counter.
  - After bit DATA_BITS-1 is stored, go to STOP.
REQ-018 STOP: when counter reaches CLKS_PER_BIT-1, the block SHALL sample serialDataIn, go to DONE, and load the output register.
  - Loading sets dataOut=shift register, dataValid=1, and framingError = NOT(sample).
REQ-019 DONE: the block SHALL assert charReceived=1 for exactly one cycle (Moore output), then go to IDLE.
REQ-020 If enable falls to 0 in START, DATA or STOP, the block SHALL go to IDLE on the next edge without pulsing charReceived and without changing the outputs.
REQ-021 Latency: the stop-bit sample SHALL occur (CLKS_PER_BIT/2) + (DATA_BITS+1)*CLKS_PER_BIT cycles after the START entry edge; charReceived SHALL assert in the following cycle.
REQ-022 Output handshake:
  - A cycle with dataValid=1 and dataReady=1 and no load SHALL clear dataValid and overrun on the next edge.
  - dataOut SHALL be held stable while dataValid=1, except when a new load occurs.
REQ-023 A load while dataValid=1 and dataReady=0 SHALL overwrite dataOut and framingError and set overrun=1.
REQ-024 A load in the same cycle as an accept SHALL leave dataValid=1 and SHALL NOT set overrun; overrun is cleared.
REQ-025 The counter SHALL be wide enough for CLKS_PER_BIT-1 and the bit index wide enough for DATA_BITS-1; neither shall wrap inside a state.
REQ-026 In IDLE and DONE, enable=1 SHALL NOT start a new frame until the block is back in IDLE.

Reset
REQ-027 While rst=0, the block SHALL be in IDLE with counter=0, bit index=0, shift register=0, charReceived=0, dataOut=0, dataValid=0, framingError=0 and overrun=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame immediately, and no partial character shall ever reach dataOut.

Verification
REQ-029 Frame 0xA5 at CLKS_PER_BIT=16 with dataReady=1 -> charReceived pulses once, 8+16*9=152 cycles after the START entry plus 1; dataOut=0xA5, dataValid=1 for one cycle, framingError=0.
REQ-030 Frame 0x3C with the stop bit driven 0 -> dataOut=0x3C, dataValid=1, framingError=1.
REQ-031 Start bit low for only 4 cycles and then high -> the START sample reads 1, charReceived pulses, dataValid stays 0.
REQ-032 Frames 0x11 then 0x22 with dataReady=0 -> dataOut=0x22, dataValid=1, overrun=1; one cycle of dataReady=1 -> dataValid=0, overrun=0.
REQ-033 Load coinciding with dataReady=1 while dataValid=1 -> the new byte is valid and overrun=0.
REQ-034 rst=0 pulsed during data bit 3, then a clean 0x5A frame -> outputs at reset values after the pulse, then dataOut=0x5A with no stale bits.
